// File: rtl/multi_bit_sync_filt.sv
// Per-bit level synchroniser with a stability filter and rise/fall pulse outputs.
// Define CHG_FLAG_EN to add the chg_clr/chg_flag sticky change-flag ports.
module multi_bit_sync_filt #(
    parameter int BUS_WIDTH     = 8,
    parameter int NUM_STAGES    = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                 dest_clk,
    input  logic                 dest_rst,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic [BUS_WIDTH-1:0] rise_pulse,
    output logic [BUS_WIDTH-1:0] fall_pulse
`ifdef CHG_FLAG_EN
    ,
    input  logic [BUS_WIDTH-1:0] chg_clr,
    output logic [BUS_WIDTH-1:0] chg_flag
`endif
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("multi_bit_sync_filt: NUM_STAGES must be at least 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("multi_bit_sync_filt: FILTER_CYCLES must be at least 1");
    end

    logic [BUS_WIDTH-1:0] r_sync [NUM_STAGES];
    logic [CNT_W-1:0]     r_cnt  [BUS_WIDTH];
    logic [BUS_WIDTH-1:0] r_sync_bus;
    logic [BUS_WIDTH-1:0] r_rise;
    logic [BUS_WIDTH-1:0] r_fall;
    logic [BUS_WIDTH-1:0] w_s;
    logic [BUS_WIDTH-1:0] w_accept;

    // Plain flop chain: nothing combinational may sit between metastability stages.
    always_ff @(posedge dest_clk) begin
        if (dest_rst) begin
            for (int k = 0; k < NUM_STAGES; k++) r_sync[k] <= '0;
        end else begin
            r_sync[0] <= unsync_bus;
            for (int k = 1; k < NUM_STAGES; k++) r_sync[k] <= r_sync[k-1];
        end
    end

    assign w_s = r_sync[NUM_STAGES-1];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            w_accept[i] = (w_s[i] != r_sync_bus[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge dest_clk) begin
        if (dest_rst) begin
            r_sync_bus <= '0;
            r_rise     <= '0;
            r_fall     <= '0;
            for (int i = 0; i < BUS_WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < BUS_WIDTH; i++) begin
                if (w_accept[i]) begin
                    r_sync_bus[i] <= w_s[i];
                    r_cnt[i]      <= '0;
                end else if (w_s[i] != r_sync_bus[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else begin
                    r_cnt[i] <= '0;
                end
            end
            r_rise <= w_accept & w_s;
            r_fall <= w_accept & ~w_s;
        end
    end

    assign sync_bus   = r_sync_bus;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

`ifdef CHG_FLAG_EN
    logic [BUS_WIDTH-1:0] r_chg_flag;

    // A change accepted on the same edge as a clear keeps the flag set.
    always_ff @(posedge dest_clk) begin
        if (dest_rst) begin
            r_chg_flag <= '0;
        end else begin
            r_chg_flag <= w_accept | (r_chg_flag & ~chg_clr);
        end
    end

    assign chg_flag = r_chg_flag;
`endif

endmodule

// File: tb/tb_multi_bit_sync_filt.sv
// Directed bench for multi_bit_sync_filt (default parameters); expected outputs
// per edge are queued ahead of stimulus and popped as each edge completes.
module tb_multi_bit_sync_filt;

    localparam int LAT = 6;  // NUM_STAGES + FILTER_CYCLES with defaults

    logic       dest_clk = 1'b0;
    logic       dest_rst;
    logic [7:0] unsync_bus;
    logic [7:0] sync_bus;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
    logic [7:0] chg_clr;
    logic [7:0] chg_flag;

    always #5 dest_clk = ~dest_clk;

    multi_bit_sync_filt dut (
        .dest_clk   (dest_clk),
        .dest_rst   (dest_rst),
        .unsync_bus (unsync_bus),
        .sync_bus   (sync_bus),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`ifdef CHG_FLAG_EN
        ,
        .chg_clr    (chg_clr),
        .chg_flag   (chg_flag)
`endif
    );

`ifndef CHG_FLAG_EN
    assign chg_flag = 8'h00;
`endif

    typedef struct {
        logic [7:0] sync;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] flag;
        bit         chk_flag;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] s, input logic [7:0] r, input logic [7:0] f,
                        input int n, input string tag,
                        input bit cf = 1'b0, input logic [7:0] fl = 8'h00);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.sync = s; e.rise = r; e.fall = f;
            e.flag = fl; e.chk_flag = cf; e.tag = tag;
            sb.push_back(e);
        end
    endtask

    // Held input change: old value for LAT-1 edges, new value with pulses at edge LAT.
    task automatic push_change(input logic [7:0] old_v, input logic [7:0] new_v, input string tag);
        push(old_v, 8'h00, 8'h00, LAT - 1, {tag, "_wait"});
        push(new_v, new_v & ~old_v, old_v & ~new_v, 1, {tag, "_edge"});
    endtask

    task automatic tick(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge dest_clk);
            #1;
            n_vec++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL sb_underrun: observed 0 entries expected at least 1");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.tag, "_sync"}, sync_bus, e.sync);
                check({e.tag, "_rise"}, rise_pulse, e.rise);
                check({e.tag, "_fall"}, fall_pulse, e.fall);
`ifdef CHG_FLAG_EN
                if (e.chk_flag) check({e.tag, "_flag"}, chg_flag, e.flag);
`endif
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dest_rst   = 1'b1;
        unsync_bus = 8'hFF;
        chg_clr    = 8'h00;

        // Reset held for 3 edges, then release with the input already high.
        push(8'h00, 8'h00, 8'h00, 3, "reset");
        tick(3);
        dest_rst = 1'b0;
        push_change(8'h00, 8'hFF, "rst_rel");
        push(8'hFF, 8'h00, 8'h00, 2, "rst_hold");
        tick(LAT + 2);

        // Falling step on the upper nibble.
        unsync_bus = 8'h0F;
        push_change(8'hFF, 8'h0F, "fall");
        push(8'h0F, 8'h00, 8'h00, 2, "fall_hold");
        tick(LAT + 2);

        unsync_bus = 8'h00;
        push_change(8'h0F, 8'h00, "to_zero");
        push(8'h00, 8'h00, 8'h00, 2, "zero_hold");
        tick(LAT + 2);

        // Mixed rising step.
        unsync_bus = 8'hA5;
        push_change(8'h00, 8'hA5, "step");
        push(8'hA5, 8'h00, 8'h00, 2, "step_hold");
        tick(LAT + 2);

        unsync_bus = 8'h00;
        push_change(8'hA5, 8'h00, "step_back");
        push(8'h00, 8'h00, 8'h00, 2, "back_hold");
        tick(LAT + 2);

        // Three-cycle pulse on bit 0 is rejected.
        push(8'h00, 8'h00, 8'h00, 12, "glitch3");
        unsync_bus = 8'h01;
        tick(3);
        unsync_bus = 8'h00;
        tick(9);

        // Four-cycle pulse on bit 0 passes, four cycles wide.
        push(8'h00, 8'h00, 8'h00, 5, "glitch4_wait");
        push(8'h01, 8'h01, 8'h00, 1, "glitch4_rise");
        push(8'h01, 8'h00, 8'h00, 3, "glitch4_high");
        push(8'h00, 8'h00, 8'h01, 1, "glitch4_fall");
        push(8'h00, 8'h00, 8'h00, 2, "glitch4_done");
        unsync_bus = 8'h01;
        tick(4);
        unsync_bus = 8'h00;
        tick(8);

        // Reset mid-filter discards the partial count.
        unsync_bus = 8'h01;
        push(8'h00, 8'h00, 8'h00, 3, "rmid_pre");
        tick(3);
        dest_rst = 1'b1;
        push(8'h00, 8'h00, 8'h00, 1, "rmid_rst");
        tick(1);
        dest_rst = 1'b0;
        push_change(8'h00, 8'h01, "rmid_rel");
        push(8'h01, 8'h00, 8'h00, 2, "rmid_hold");
        tick(LAT + 2);

`ifdef CHG_FLAG_EN
        chg_clr = 8'hFF;
        push(8'h01, 8'h00, 8'h00, 1, "flag_clrall", 1'b1, 8'h00);
        tick(1);
        chg_clr = 8'h00;

        unsync_bus = 8'h09;
        push(8'h01, 8'h00, 8'h00, LAT - 1, "flag_wait", 1'b1, 8'h00);
        push(8'h09, 8'h08, 8'h00, 1, "flag_set", 1'b1, 8'h08);
        push(8'h09, 8'h00, 8'h00, 3, "flag_held", 1'b1, 8'h08);
        tick(LAT + 3);

        unsync_bus = 8'h01;
        push(8'h09, 8'h00, 8'h00, LAT - 1, "flag_fwait", 1'b1, 8'h08);
        tick(LAT - 1);
        chg_clr = 8'h08;
        push(8'h01, 8'h00, 8'h08, 1, "flag_setwin", 1'b1, 8'h08);
        tick(1);
        chg_clr = 8'h00;
        push(8'h01, 8'h00, 8'h00, 1, "flag_after", 1'b1, 8'h08);
        tick(1);
        chg_clr = 8'h08;
        push(8'h01, 8'h00, 8'h00, 1, "flag_clr", 1'b1, 8'h00);
        tick(1);
        chg_clr = 8'h00;
        push(8'h01, 8'h00, 8'h00, 1, "flag_clred", 1'b1, 8'h00);
        tick(1);
`endif

        n_vec++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
